// File: rtl/bound_flasher_monitor.sv
// Passive decoder for the bound_flasher LED bus: recovers level, sweep direction,
// turning points, sweep/abort counts and sticky pattern/step errors.
`timescale 1ns/1ps

module bound_flasher_monitor #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned IDLE_CYCLES = 4,
  localparam int unsigned LW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] led,
  output logic [LW-1:0]    level,
  output logic [1:0]       dir,
  output logic [LW-1:0]    peak,
  output logic [LW-1:0]    trough,
  output logic             sweep_done,
  output logic [7:0]       sweep_cnt,
  output logic [7:0]       abort_cnt,
  output logic             err_pattern,
  output logic             err_step
);

  localparam int unsigned XW = LW + 1;
  localparam int unsigned CW = 8;
  localparam int unsigned HW = 8;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  dir_t             state;
  dir_t             state_nxt;
  logic [WIDTH-1:0] led_q;
  logic [LW-1:0]    lit_cnt;
  logic             legal;
  logic             s1_valid;
  logic [LW-1:0]    prv_lvl;
  logic [HW-1:0]    hold_cnt;

  logic [XW-1:0]    cur_x;
  logic [XW-1:0]    prv_x;
  logic             step_up;
  logic             step_down;
  logic             step_hold;
  logic             step_abort;
  logic             hold_done;

  logic [LW-1:0]    peak_nxt;
  logic [LW-1:0]    trough_nxt;
  logic [LW-1:0]    prv_nxt;
  logic [HW-1:0]    hold_nxt;
  logic             done_nxt;
  logic [CW-1:0]    sweep_nxt;
  logic [CW-1:0]    abort_nxt;
  logic             err_step_nxt;

  // S0: raw sample
  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= led;
  end

  // S1 decode: legal iff led_q is a run of ones starting at bit 0
  always_comb begin
    lit_cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) lit_cnt = lit_cnt + LW'(led_q[i]);
    legal = ((led_q & (led_q + WIDTH'(1))) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level       <= '0;
      s1_valid    <= 1'b0;
      err_pattern <= 1'b0;
    end else begin
      s1_valid <= legal;
      if (legal) level <= lit_cnt;
      if (clr)         err_pattern <= 1'b0;
      else if (!legal) err_pattern <= 1'b1;
    end
  end

  // S2 step classification of level against the previous legal level
  always_comb begin
    cur_x      = {1'b0, level};
    prv_x      = {1'b0, prv_lvl};
    step_up    = (cur_x == prv_x + XW'(1));
    step_down  = (cur_x + XW'(1) == prv_x);
    step_hold  = (level == prv_lvl);
    step_abort = (level == '0) && (prv_lvl >= LW'(2));
    hold_done  = (hold_cnt == HW'(IDLE_CYCLES - 1));
  end

  // Direction state register
  always_ff @(posedge clk) begin
    if (rst) state <= DIR_IDLE;
    else     state <= state_nxt;
  end

  // Direction next-state
  always_comb begin
    state_nxt = state;
    if (s1_valid) begin
      if (step_up)                     state_nxt = DIR_UP;
      else if (step_down)              state_nxt = DIR_DOWN;
      else if (step_abort)             state_nxt = DIR_IDLE;
      else if (step_hold && hold_done) state_nxt = DIR_IDLE;
    end
  end

  // S2 outputs; an illegal step leaves dir, peak and trough untouched
  always_comb begin
    peak_nxt     = peak;
    trough_nxt   = trough;
    prv_nxt      = prv_lvl;
    hold_nxt     = hold_cnt;
    done_nxt     = 1'b0;
    sweep_nxt    = sweep_cnt;
    abort_nxt    = abort_cnt;
    err_step_nxt = err_step;
    if (s1_valid) begin
      prv_nxt  = level;
      hold_nxt = '0;
      if (step_hold) begin
        if (hold_cnt != HW'(IDLE_CYCLES)) hold_nxt = hold_cnt + HW'(1);
        else                              hold_nxt = hold_cnt;
      end
      if (step_up && state == DIR_DOWN) trough_nxt = prv_lvl;
      if (step_down && state == DIR_UP) peak_nxt = prv_lvl;
      if (step_down && level == '0) begin
        done_nxt = 1'b1;
        if (sweep_cnt != '1) sweep_nxt = sweep_cnt + CW'(1);
      end
      if (step_abort && abort_cnt != '1) abort_nxt = abort_cnt + CW'(1);
      if (!step_up && !step_down && !step_hold && !step_abort) err_step_nxt = 1'b1;
    end
    if (clr) begin
      sweep_nxt    = '0;
      abort_nxt    = '0;
      err_step_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak       <= '0;
      trough     <= '0;
      prv_lvl    <= '0;
      hold_cnt   <= '0;
      sweep_done <= 1'b0;
      sweep_cnt  <= '0;
      abort_cnt  <= '0;
      err_step   <= 1'b0;
    end else begin
      peak       <= peak_nxt;
      trough     <= trough_nxt;
      prv_lvl    <= prv_nxt;
      hold_cnt   <= hold_nxt;
      sweep_done <= done_nxt;
      sweep_cnt  <= sweep_nxt;
      abort_cnt  <= abort_nxt;
      err_step   <= err_step_nxt;
    end
  end

  assign dir = state;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Directed-vector bench for bound_flasher_monitor; S2 outputs lag the driven led by two edges.
`timescale 1ns/1ps

module tb_bound_flasher_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [15:0] led;
  logic [4:0]  level;
  logic [1:0]  dir;
  logic [4:0]  peak;
  logic [4:0]  trough;
  logic        sweep_done;
  logic [7:0]  sweep_cnt;
  logic [7:0]  abort_cnt;
  logic        err_pattern;
  logic        err_step;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;

  bound_flasher_monitor dut (
    .clk(clk), .rst(rst), .clr(clr), .led(led),
    .level(level), .dir(dir), .peak(peak), .trough(trough),
    .sweep_done(sweep_done), .sweep_cnt(sweep_cnt), .abort_cnt(abort_cnt),
    .err_pattern(err_pattern), .err_step(err_step)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] therm(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  task automatic step(input logic [15:0] v);
    led = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, " level"},       32'(level),       0);
    chk({ph, " dir"},         32'(dir),         0);
    chk({ph, " peak"},        32'(peak),        0);
    chk({ph, " trough"},      32'(trough),      0);
    chk({ph, " sweep_done"},  32'(sweep_done),  0);
    chk({ph, " sweep_cnt"},   32'(sweep_cnt),   0);
    chk({ph, " abort_cnt"},   32'(abort_cnt),   0);
    chk({ph, " err_pattern"}, 32'(err_pattern), 0);
    chk({ph, " err_step"},    32'(err_step),    0);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    led = '0;
    step(16'h0000);
    step(16'h0000);
    chk_reset("por");
    rst = 1'b0;

    // Full ramp up and down
    pulses = 0;
    for (int n = 1; n <= 16; n++) begin
      step(therm(n));
      if (sweep_done) pulses++;
      if (n == 8) begin
        chk("ramp level lag", 32'(level), 7);
        chk("ramp dir up",    32'(dir),   1);
      end
    end
    for (int n = 15; n >= 0; n--) begin
      step(therm(n));
      if (sweep_done) pulses++;
      if (n == 13) begin
        chk("ramp peak",     32'(peak), 16);
        chk("ramp dir down", 32'(dir),  2);
      end
    end
    step(16'h0000); if (sweep_done) pulses++;
    step(16'h0000); if (sweep_done) pulses++;
    chk("ramp sweep_done", 32'(sweep_done), 1);
    step(16'h0000); if (sweep_done) pulses++;
    chk("ramp one pulse",   32'(pulses),      1);
    chk("ramp sweep_cnt",   32'(sweep_cnt),   1);
    chk("ramp err_step",    32'(err_step),    0);
    chk("ramp err_pattern", 32'(err_pattern), 0);

    clr = 1'b1;
    step(16'h0000);
    clr = 1'b0;
    chk("clr sweep_cnt", 32'(sweep_cnt), 0);

    // 0->6, 5, up to 10, down to 0
    for (int n = 1; n <= 6; n++) step(therm(n));
    step(therm(5));
    step(therm(6));
    step(therm(7));
    chk("turn peak 6", 32'(peak), 6);
    chk("turn dir dn", 32'(dir),  2);
    step(therm(8));
    chk("turn trough 5", 32'(trough), 5);
    chk("turn dir up",   32'(dir),    1);
    for (int n = 9; n <= 10; n++) step(therm(n));
    for (int n = 9; n >= 0; n--) step(therm(n));
    step(16'h0000);
    step(16'h0000);
    chk("turn peak 10",    32'(peak),       10);
    chk("turn trough end", 32'(trough),     5);
    chk("turn sweep_done", 32'(sweep_done), 1);
    chk("turn sweep_cnt",  32'(sweep_cnt),  1);
    chk("turn err_step",   32'(err_step),   0);

    // Hold at 0x00FF after an up-ramp
    for (int n = 1; n <= 8; n++) step(therm(n));
    for (int h = 1; h <= 5; h++) step(therm(8));
    chk("hold 3 still up", 32'(dir), 1);
    step(therm(8));
    chk("hold 4 idle",  32'(dir),   0);
    chk("hold level 8", 32'(level), 8);

    // Abort from level 5
    step(therm(7));
    step(therm(6));
    step(therm(5));
    step(16'h0000);
    step(16'h0000);
    chk("abort pre dir", 32'(dir), 2);
    step(16'h0000);
    chk("abort cnt",        32'(abort_cnt),  1);
    chk("abort dir idle",   32'(dir),        0);
    chk("abort sweep_cnt",  32'(sweep_cnt),  1);
    chk("abort sweep_done", 32'(sweep_done), 0);
    chk("abort err_step",   32'(err_step),   0);
    chk("abort peak kept",  32'(peak),       10);

    // Illegal jump 2 -> 6
    step(therm(1));
    step(therm(2));
    step(therm(6));
    step(therm(6));
    chk("jump pre err", 32'(err_step), 0);
    chk("jump pre dir", 32'(dir),      1);
    step(therm(6));
    chk("jump err_step",  32'(err_step),  1);
    chk("jump dir kept",  32'(dir),       1);
    chk("jump abort_cnt", 32'(abort_cnt), 1);

    // Illegal pattern between 0x0003 and 0x0007
    clr = 1'b1;
    step(therm(5));
    clr = 1'b0;
    chk("clr err_step",  32'(err_step),  0);
    chk("clr abort_cnt", 32'(abort_cnt), 0);
    step(therm(4));
    step(therm(3));
    step(therm(2));
    step(16'h0005);
    step(therm(3));
    chk("pat level held",  32'(level),       2);
    chk("pat err_pattern", 32'(err_pattern), 1);
    step(therm(3));
    chk("pat level 3",  32'(level), 3);
    chk("pat dir down", 32'(dir),   2);
    step(therm(3));
    chk("pat step up",      32'(dir),         1);
    chk("pat no err_step",  32'(err_step),    0);
    chk("pat still sticky", 32'(err_pattern), 1);
    clr = 1'b1;
    step(therm(3));
    clr = 1'b0;
    chk("pat clr", 32'(err_pattern), 0);

    // Reset mid down-ramp at level 9
    for (int n = 4; n <= 12; n++) step(therm(n));
    for (int n = 11; n >= 8; n--) step(therm(n));
    chk("pre-rst level", 32'(level), 9);
    chk("pre-rst dir",   32'(dir),   2);
    rst = 1'b1;
    step(therm(7));
    chk_reset("mid");
    rst = 1'b0;

    // 256 full sweeps: counter saturates at 255
    pulses = 0;
    for (int s = 0; s < 256; s++) begin
      for (int n = 1; n <= 16; n++) begin
        step(therm(n));
        if (sweep_done) pulses++;
      end
      for (int n = 15; n >= 0; n--) begin
        step(therm(n));
        if (sweep_done) pulses++;
      end
    end
    step(16'h0000); if (sweep_done) pulses++;
    step(16'h0000); if (sweep_done) pulses++;
    chk("sat pulses",    32'(pulses),      256);
    chk("sat sweep_cnt", 32'(sweep_cnt),   255);
    chk("sat peak",      32'(peak),        16);
    chk("sat trough",    32'(trough),      0);
    chk("sat abort_cnt", 32'(abort_cnt),   0);
    chk("sat err_step",  32'(err_step),    0);
    chk("sat err_pat",   32'(err_pattern), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bound_flasher_monitor.md
# bound_flasher_monitor

Passive observer on the receiving end of the bound_flasher LED bus. It samples the 16-bit thermometer-coded LED output every clock and decodes it back into a lit-LED level, a sweep direction and turning points. It also counts completed sweeps and aborts, and flags illegal patterns or illegal steps. It sits beside bound_flasher in the bench and in the FPGA top, so it can be used as a self-check and for debug readout.

## Interface
- WIDTH, 16: number of LED lines observed; LW = $clog2(WIDTH+1) = 5.
- IDLE_CYCLES, 4: consecutive unchanged legal levels after which dir drops to IDLE (range 1..255).
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of sticky errors and counters; state and level are kept.
- led  in  WIDTH  LED bus from bound_flasher.
- level  out  LW  number of lit LEDs in the last legal pattern.
- dir  out  2  00 IDLE, 01 UP, 10 DOWN (11 never driven).
- peak  out  LW  level at the last UP→DOWN turn.
- trough  out  LW  level at the last DOWN→UP turn.
- sweep_done  out  1  one-cycle pulse when a sweep completes.
- sweep_cnt  out  8  completed sweeps, saturates at 255.
- abort_cnt  out  8  jumps to 0 from level ≥2, saturates at 255.
- err_pattern  out  1  sticky; a non-thermometer pattern was seen.
- err_step  out  1  sticky; an illegal level step was seen.

## Operation
- Stage S0: led is registered into led_q unconditionally.
- Stage S1: decode led_q.
  - Legal iff led_q == (1<<n)-1 for some n in 0..WIDTH.
  - If legal, cur_lvl = n. Otherwise cur_lvl holds its previous value and err_pattern is set.
- Stage S2: compare cur_lvl with prv_lvl, only in cycles where S1 was legal. Then prv_lvl ← cur_lvl.
  - d = +1: dir ← UP. If the previous dir was DOWN, trough ← prv_lvl.
  - d = −1: dir ← DOWN. If the previous dir was UP, peak ← prv_lvl.
  - d = −1 with cur_lvl = 0: sweep_done pulses and sweep_cnt increments.
  - d = 0: the hold counter increments. When it reaches IDLE_CYCLES, dir ← IDLE. Any nonzero d clears the counter.
  - cur_lvl = 0 with prv_lvl ≥ 2: counts as an abort (flasher reset). abort_cnt increments, dir ← IDLE, hold counter clears, no error.
  - Any other |d| ≥ 2: err_step set; dir, peak and trough unchanged.
- Illegal-pattern cycles do not advance the hold counter, do not update prv_lvl, and do not generate steps.
- clr zeroes sweep_cnt, abort_cnt, err_pattern and err_step at the next edge.
  - If clr and an increment or error occur in the same cycle, clr wins.
- Counters saturate at 255 and do not wrap.
- Reset values:
  - level = 0, dir = IDLE, peak = 0, trough = 0.
  - sweep_done = 0, sweep_cnt = 0, abort_cnt = 0.
  - err_pattern = 0, err_step = 0.
  - led_q = 0, prv_lvl = 0, hold counter = 0.
- rst has priority over clr and over all updates. The pipeline is flushed: the first post-reset sample is compared against prv_lvl = 0.

## Timing
- led sampled at edge N → led_q valid after N.
- level and err_pattern update at edge N+1.
- dir, peak, trough, sweep_done, counters and err_step update at edge N+2.
- Total latency from led change to dir/sweep outputs is 2 cycles. The output view is consistent: all S2 outputs come from the same sample.
- sweep_done is high for exactly one cycle per completing step.
- A reset asserted mid-sweep clears state at that edge. Samples captured at or before the reset edge are discarded. There is no partial-update cycle.
- Throughput: one sample per clock, no stalls, no handshake.

## Test plan
- Ramp led 0x0000→0xFFFF one bit per clock, then back to 0x0000 → level tracks n with 1-cycle lag; dir=UP then DOWN; peak=16; sweep_done pulses once; sweep_cnt=1; no errors.
- Ramp 0→6, down to 5, up to 10, down to 0 → peak=6, then trough=5, then peak=10; sweep_cnt=1; err_step=0.
- Hold led=0x00FF for 6 clocks after an up-ramp → dir goes IDLE exactly IDLE_CYCLES=4 legal holds after the last step; level=8.
- Ramp to 0x001F, then force 0x0000 (flasher reset) → abort_cnt=1, dir=IDLE, sweep_cnt unchanged, err_step=0. Then jump 0x0003→0x003F → err_step=1.
- Inject 0x0005 between 0x0003 and 0x0007 → err_pattern=1; level holds 2 for that cycle; the 2→3 step is still seen as a legal UP; clr → err_pattern=0 next cycle.
- Assert rst during a down-ramp at level 9; drive 256 full sweeps → all outputs return to reset values one edge after rst; sweep_cnt stops at 255.
